// File: rtl/int_ctrl_if.sv
// int_ctrl_if: CPU/device-side bus of the interrupt controller.
// Ports: irq_in (raw lines), addr/we/wdata/rdata (register window), int_ack/hw_int (CPU handshake).
// master = CPU/bench side, slave = controller side.
interface int_ctrl_if;
  logic [5:0]  irq_in;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic [5:0]  hw_int;

  modport master (
    output irq_in, addr, we, wdata, int_ack,
    input  rdata, hw_int
  );

  modport slave (
    input  irq_in, addr, we, wdata, int_ack,
    output rdata, hw_int
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: 6-source interrupt controller, per-source mask and edge/level mode, fixed lowest-index priority.
// Latency: level source -> hw_int 2 cycles after sampling (SYNC_EN=1), edge source 3 cycles; SYNC_EN=0 two fewer.
// Backpressure: one request outstanding; later requests wait in PEND until EOI.
// Ports: i_clk, i_reset (sync, active-high), io_bus (int_ctrl_if.slave: irq_in, addr, we, wdata, rdata, int_ack, hw_int).
module int_ctrl #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic     i_clk,
  input  logic     i_reset,
  int_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t     r_state;
  logic [5:0] r_s1, r_s2, r_prev;
  logic [5:0] r_mask, r_mode, r_pend_edge, r_insrv, r_hw_int;
  logic       r_vec_vld;
  logic [2:0] r_vec_idx;

  logic [5:0] w_s, w_rise, w_pend, w_cand, w_sel;
  logic [5:0] w_mode_nxt, w_w1c, w_ack_clr, w_pend_edge_nxt;
  logic       w_ack, w_eoi;

  function automatic logic [2:0] f_idx(input logic [5:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  generate
    if (SYNC_EN) begin : g_sync
      assign w_s = r_s2;
    end else begin : g_nosync
      assign w_s = io_bus.irq_in;
    end
  endgenerate

  assign w_rise     = w_s & ~r_prev;
  assign w_mode_nxt = (io_bus.we && io_bus.addr == 3'd1) ? io_bus.wdata[5:0] : r_mode;
  assign w_w1c      = (io_bus.we && io_bus.addr == 3'd2) ? io_bus.wdata[5:0] : 6'd0;
  assign w_ack      = (r_state == ST_REQ) && io_bus.int_ack;
  assign w_eoi      = (r_state == ST_SERVICE) && io_bus.we && (io_bus.addr == 3'd5);
  // Acceptance clears the bit that was actually presented (registered hw_int).
  assign w_ack_clr  = w_ack ? r_hw_int : 6'd0;

  // New edge overrides W1C/ack clears; masking with the next MODE drops
  // latched edges on bits being switched to level.
  assign w_pend_edge_nxt = ((r_pend_edge & ~(w_w1c | w_ack_clr)) | (w_rise & r_mode)) & w_mode_nxt;

  assign w_pend = (r_mode & r_pend_edge) | (~r_mode & w_s);
  assign w_cand = w_pend & r_mask;
  assign w_sel  = w_cand & (~w_cand + 6'd1);  // isolate lowest set bit

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_prev      <= '0;
      r_mask      <= '0;
      r_mode      <= '0;
      r_pend_edge <= '0;
      r_insrv     <= '0;
      r_vec_vld   <= 1'b0;
      r_vec_idx   <= '0;
      r_hw_int    <= '0;
      r_state     <= ST_IDLE;
    end else begin
      r_s1        <= io_bus.irq_in;
      r_s2        <= r_s1;
      r_prev      <= w_s;
      r_mode      <= w_mode_nxt;
      r_pend_edge <= w_pend_edge_nxt;
      if (io_bus.we && io_bus.addr == 3'd0) r_mask <= io_bus.wdata[5:0];

      case (r_state)
        ST_IDLE: begin
          if (w_cand != 6'd0) begin
            r_hw_int <= w_sel;
            r_state  <= ST_REQ;
          end else begin
            r_hw_int <= '0;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            r_insrv   <= r_hw_int;
            r_vec_vld <= 1'b1;
            r_vec_idx <= f_idx(r_hw_int);
            r_hw_int  <= '0;
            r_state   <= ST_SERVICE;
          end else if (w_cand != 6'd0) begin
            r_hw_int <= w_sel;   // a higher-priority arrival pre-empts here
          end else begin
            r_hw_int <= '0;
            r_state  <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          r_hw_int <= '0;
          if (w_eoi) begin
            r_insrv   <= '0;
            r_vec_vld <= 1'b0;
            r_vec_idx <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_hw_int <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    io_bus.rdata = 32'd0;
    case (io_bus.addr)
      3'd0:    io_bus.rdata = {26'd0, r_mask};
      3'd1:    io_bus.rdata = {26'd0, r_mode};
      3'd2:    io_bus.rdata = {26'd0, w_pend};
      3'd3:    io_bus.rdata = {26'd0, r_insrv};
      3'd4:    io_bus.rdata = {r_vec_vld, 28'd0, r_vec_idx};
      default: io_bus.rdata = 32'd0;
    endcase
  end

  assign io_bus.hw_int = r_hw_int;

endmodule
